// File: rtl/sram_arbiter2_pkg.sv
// Shared types for the two-port SRAM arbiter: request bundle, FSM states
// and the port count.
package sram_arbiter2_pkg;

    localparam int SRAM_ARB_PORTS       = 2;
    localparam int CFG_SYSBUS_ADDR_BITS = 32;

    typedef struct packed {
        logic [CFG_SYSBUS_ADDR_BITS-1:0] addr;
        logic                            write;
        logic [7:0]                      wstrb;
        logic [63:0]                     wdata;
        logic                            last;
    } sram_req_type;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin grant with an optional lock that pins
// the grant to one port (used to keep bursts contiguous).
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       rr_last,
    input  logic       lock_en,
    input  logic       lock_idx,
    output logic [1:0] grant
);

    // Locked: only the owner may go. Unlocked: single requester wins, ties go
    // to the port that was not served last.
    always_comb begin
        grant = 2'b00;
        if (lock_en) begin
            grant[lock_idx] = valid[lock_idx];
        end else if (valid == 2'b11) begin
            grant = rr_last ? 2'b01 : 2'b10;
        end else begin
            grant = valid;
        end
    end

endmodule

// File: rtl/sram_arbiter2.sv
// Two-requester arbiter in front of a single-port byte-strobed SRAM with
// 1-cycle read latency. Round-robin between ports, burst lock until the
// req_last beat, response pulse routed back one cycle after acceptance.
// Optional statistics counters are enabled with SRAM_ARBITER2_STAT_EN.
module sram_arbiter2
    import sram_arbiter2_pkg::*;
#(
    parameter int abits       = 17,
    parameter int log2_dbytes = 3
) (
    input  logic                        clk,
    input  logic                        nrst,
    input  logic [1:0]                  i_req_valid,
    output logic [1:0]                  o_req_ready,
    input  logic [1:0][abits-1:0]       i_req_addr,
    input  logic [1:0]                  i_req_write,
    input  logic [1:0][7:0]             i_req_wstrb,
    input  logic [1:0][63:0]            i_req_wdata,
    input  logic [1:0]                  i_req_last,
    output logic [1:0]                  o_resp_valid,
    output logic [(8<<log2_dbytes)-1:0] o_resp_rdata,
    output logic [abits-1:0]            o_sram_addr,
    output logic                        o_sram_we,
    output logic [7:0]                  o_sram_wstrb,
    output logic [(8<<log2_dbytes)-1:0] o_sram_wdata,
`ifdef SRAM_ARBITER2_STAT_EN
    output logic [1:0][31:0]            o_stat_grant,
    output logic [31:0]                 o_stat_conflict,
`endif
    input  logic [(8<<log2_dbytes)-1:0] i_sram_rdata
);

    sram_req_type [SRAM_ARB_PORTS-1:0] req;
    sram_req_type                      sel;
    arb_state_e                        state_q, state_d;
    logic                              rr_last_q, rr_last_d;
    logic [1:0]                        resp_pend_q, resp_pend_d;
    logic [1:0]                        grant_raw, grant;
    logic                              any_grant;
    logic                              unused_addr_hi;

    // Bundle per-port request fields into the shared request struct.
    always_comb begin
        req = '0;
        for (int n = 0; n < SRAM_ARB_PORTS; n++) begin
            req[n].addr  = CFG_SYSBUS_ADDR_BITS'(i_req_addr[n]);
            req[n].write = i_req_write[n];
            req[n].wstrb = i_req_wstrb[n];
            req[n].wdata = i_req_wdata[n];
            req[n].last  = i_req_last[n];
        end
    end

    rr_arbiter2 u_rr (
        .valid    (i_req_valid),
        .rr_last  (rr_last_q),
        .lock_en  (state_q != IDLE),
        .lock_idx (state_q == LOCK1),
        .grant    (grant_raw)
    );

    // Nothing is granted while reset is held, even if requests are valid.
    assign grant     = nrst ? grant_raw : 2'b00;
    assign any_grant = |grant;
    assign sel       = grant[1] ? req[1] : req[0];

    assign o_req_ready    = grant;
    assign o_resp_valid   = nrst ? resp_pend_q : 2'b00;
    assign o_resp_rdata   = i_sram_rdata;
    assign o_sram_addr    = sel.addr[abits-1:0];
    assign o_sram_we      = any_grant & sel.write;
    assign o_sram_wstrb   = any_grant ? sel.wstrb : 8'h00;
    assign o_sram_wdata   = sel.wdata;
    assign unused_addr_hi = ^sel.addr[CFG_SYSBUS_ADDR_BITS-1:abits];

    // Next-state: accepted beat updates round-robin history and burst lock.
    always_comb begin
        state_d     = state_q;
        rr_last_d   = rr_last_q;
        resp_pend_d = grant;
        if (any_grant) begin
            rr_last_d = grant[1];
            if (sel.last) begin
                state_d = IDLE;
            end else begin
                state_d = grant[1] ? LOCK1 : LOCK0;
            end
        end
    end

    // Arbiter state; reset releases any lock and drops pending responses.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= IDLE;
            rr_last_q   <= 1'b1;
            resp_pend_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            rr_last_q   <= rr_last_d;
            resp_pend_q <= resp_pend_d;
        end
    end

`ifdef SRAM_ARBITER2_STAT_EN
    logic [1:0][31:0] stat_grant_q, stat_grant_d;
    logic [31:0]      stat_conflict_q, stat_conflict_d;

    // Free-running wrap-around counters: accepted beats per port and
    // unlocked cycles where both ports competed.
    always_comb begin
        for (int n = 0; n < SRAM_ARB_PORTS; n++) begin
            stat_grant_d[n] = stat_grant_q[n] + 32'(grant[n]);
        end
        stat_conflict_d = stat_conflict_q
                        + 32'((state_q == IDLE) && (i_req_valid == 2'b11));
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            stat_grant_q    <= '0;
            stat_conflict_q <= '0;
        end else begin
            stat_grant_q    <= stat_grant_d;
            stat_conflict_q <= stat_conflict_d;
        end
    end

    assign o_stat_grant    = stat_grant_q;
    assign o_stat_conflict = stat_conflict_q;
`endif

endmodule

// File: tb/tb_sram_arbiter2.sv
// Self-checking bench for sram_arbiter2: directed test-plan sequences with
// literal expectations, then randomized traffic checked every cycle against
// a transaction-level model (lock owner, last winner, reference memory).
module tb_sram_arbiter2;

    localparam int AB    = 17;
    localparam int WORDS = 1 << (AB - 3);

    logic              clk = 1'b0;
    logic              nrst = 1'b0;
    logic [1:0]        i_req_valid, o_req_ready, i_req_write, i_req_last, o_resp_valid;
    logic [1:0][AB-1:0] i_req_addr;
    logic [1:0][7:0]   i_req_wstrb;
    logic [1:0][63:0]  i_req_wdata;
    logic [63:0]       o_resp_rdata, o_sram_wdata, i_sram_rdata;
    logic [AB-1:0]     o_sram_addr;
    logic              o_sram_we;
    logic [7:0]        o_sram_wstrb;
`ifdef SRAM_ARBITER2_STAT_EN
    logic [1:0][31:0]  o_stat_grant;
    logic [31:0]       o_stat_conflict;
`endif

    int total = 0;
    int bad   = 0;

    sram_arbiter2 #(.abits(AB), .log2_dbytes(3)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_addr   (i_req_addr),
        .i_req_write  (i_req_write),
        .i_req_wstrb  (i_req_wstrb),
        .i_req_wdata  (i_req_wdata),
        .i_req_last   (i_req_last),
        .o_resp_valid (o_resp_valid),
        .o_resp_rdata (o_resp_rdata),
        .o_sram_addr  (o_sram_addr),
        .o_sram_we    (o_sram_we),
        .o_sram_wstrb (o_sram_wstrb),
        .o_sram_wdata (o_sram_wdata),
`ifdef SRAM_ARBITER2_STAT_EN
        .o_stat_grant    (o_stat_grant),
        .o_stat_conflict (o_stat_conflict),
`endif
        .i_sram_rdata (i_sram_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                          input logic [7:0] s);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    // SRAM behavioural model: 1-cycle read latency, byte-strobed writes.
    logic [63:0] sram_mem [0:WORDS-1];
    // Reference memory maintained by the model from accepted requests.
    logic [63:0] ref_mem  [0:WORDS-1];

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            sram_mem[i] = 64'h0;
            ref_mem[i]  = 64'h0;
        end
    end

    always @(posedge clk) begin
        if (o_sram_we)
            sram_mem[o_sram_addr[AB-1:3]] <= merge(sram_mem[o_sram_addr[AB-1:3]], o_sram_wdata, o_sram_wstrb);
        else
            i_sram_rdata <= sram_mem[o_sram_addr[AB-1:3]];
    end

    // Transaction-level model: who owns the lock (-1 none), who won last,
    // which port expects a response next cycle and with what data.
    int          m_owner = -1, n_owner = -1;
    bit          m_last  = 1'b1, n_last = 1'b1;
    logic [1:0]  m_pend  = 2'b00, n_pend = 2'b00;
    bit          m_pend_rd = 1'b0, n_pend_rd = 1'b0;
    logic [63:0] m_pend_data = 64'h0, n_pend_data = 64'h0;

    always @(negedge clk) begin
        logic [1:0] eg;
        int p;
        int k;
        eg = 2'b00;
        if (nrst) begin
            if (m_owner >= 0) begin
                if (i_req_valid[m_owner]) eg[m_owner] = 1'b1;
            end else if (i_req_valid == 2'b11) begin
                eg[m_last ? 0 : 1] = 1'b1;
            end else begin
                eg = i_req_valid;
            end
        end
        chk("ready", 64'(o_req_ready), 64'(eg));
        chk("resp_valid", 64'(o_resp_valid), 64'(nrst ? m_pend : 2'b00));
        if (nrst && m_pend != 2'b00 && m_pend_rd)
            chk("resp_rdata", o_resp_rdata, m_pend_data);
        n_pend = eg; n_pend_rd = 1'b0; n_pend_data = 64'h0;
        n_owner = m_owner; n_last = m_last;
        if (eg != 2'b00) begin
            p = eg[1] ? 1 : 0;
            k = int'(i_req_addr[p][AB-1:3]);
            chk("sram_we", 64'(o_sram_we), 64'(i_req_write[p]));
            chk("sram_addr", 64'(o_sram_addr), 64'(i_req_addr[p]));
            chk("sram_wstrb", 64'(o_sram_wstrb), 64'(i_req_wstrb[p]));
            if (i_req_write[p]) begin
                chk("sram_wdata", o_sram_wdata, i_req_wdata[p]);
                ref_mem[k] = merge(ref_mem[k], i_req_wdata[p], i_req_wstrb[p]);
            end else begin
                n_pend_rd   = 1'b1;
                n_pend_data = ref_mem[k];
            end
            n_last  = (p == 1);
            n_owner = i_req_last[p] ? -1 : p;
        end else begin
            chk("idle_we", 64'(o_sram_we), 64'h0);
            chk("idle_wstrb", 64'(o_sram_wstrb), 64'h0);
        end
        if (!nrst) begin
            n_owner = -1; n_last = 1'b1; n_pend = 2'b00; n_pend_rd = 1'b0;
        end
    end

    always @(posedge clk) begin
        m_owner     <= n_owner;
        m_last      <= n_last;
        m_pend      <= n_pend;
        m_pend_rd   <= n_pend_rd;
        m_pend_data <= n_pend_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setp(input int p, input logic [AB-1:0] a, input bit w,
                        input logic [7:0] s, input logic [63:0] d, input bit l);
        i_req_addr[p]  = a;
        i_req_write[p] = w;
        i_req_wstrb[p] = s;
        i_req_wdata[p] = d;
        i_req_last[p]  = l;
    endtask

    initial begin
        int g0, g1;
        i_req_valid = 2'b11;
        setp(0, AB'(0), 1'b0, 8'h00, 64'h0, 1'b1);
        setp(1, AB'(0), 1'b0, 8'h00, 64'h0, 1'b1);
        nrst = 1'b0;

        // reset holds everything off even with valid requests
        step(); step();
        @(negedge clk);
        chk("rst_ready", 64'(o_req_ready), 64'h0);
        chk("rst_resp", 64'(o_resp_valid), 64'h0);
        chk("rst_we", 64'(o_sram_we), 64'h0);

        // simultaneous reads after reset: port 0 first, then port 1
        step();
        nrst = 1'b1;
        i_req_valid = 2'b11;
        setp(0, AB'(17'h100), 1'b0, 8'h00, 64'h0, 1'b1);
        setp(1, AB'(17'h200), 1'b0, 8'h00, 64'h0, 1'b1);
        @(negedge clk);
        chk("t1_ready_c0", 64'(o_req_ready), 64'h1);
        chk("t1_addr_c0", 64'(o_sram_addr), 64'h100);
        step();
        i_req_valid = 2'b10;
        @(negedge clk);
        chk("t1_ready_c1", 64'(o_req_ready), 64'h2);
        chk("t1_addr_c1", 64'(o_sram_addr), 64'h200);
        chk("t1_resp_c1", 64'(o_resp_valid), 64'h1);
        step();
        i_req_valid = 2'b00;
        @(negedge clk);
        chk("t1_resp_c2", 64'(o_resp_valid), 64'h2);

        // port 1 writes, port 0 reads it back
        step();
        i_req_valid = 2'b10;
        setp(1, AB'(17'h40), 1'b1, 8'hFF, 64'hDEADBEEF_01234567, 1'b1);
        step();
        i_req_valid = 2'b01;
        setp(0, AB'(17'h40), 1'b0, 8'h00, 64'h0, 1'b1);
        @(negedge clk);
        chk("t2_ready", 64'(o_req_ready), 64'h1);
        step();
        i_req_valid = 2'b00;
        @(negedge clk);
        chk("t2_resp", 64'(o_resp_valid), 64'h1);
        chk("t2_rdata", o_resp_rdata, 64'hDEADBEEF_01234567);

        // 4-beat burst on port 0 holds off a continuously valid port 1
        step();
        i_req_valid = 2'b10;
        setp(1, AB'(17'h80), 1'b0, 8'h00, 64'h0, 1'b1);
        for (int b = 1; b <= 4; b++) begin
            step();
            i_req_valid = 2'b11;
            setp(0, AB'(17'h400 + 17'(b * 8)), 1'b1, 8'h0F, 64'(b) * 64'h1111, b == 4);
            @(negedge clk);
            chk("t3_burst_ready", 64'(o_req_ready), 64'h1);
        end
        step();
        setp(0, AB'(17'h408), 1'b0, 8'h00, 64'h0, 1'b1);
        @(negedge clk);
        chk("t3_p1_after", 64'(o_req_ready), 64'h2);

        // alternating grants under continuous contention
        step();
        nrst = 1'b0;
        i_req_valid = 2'b00;
        step();
        nrst = 1'b1;
        g0 = 0; g1 = 0;
        for (int i = 0; i < 10; i++) begin
            i_req_valid = 2'b11;
            setp(0, AB'($urandom_range(0, 15) << 3), 1'b0, 8'h00, 64'h0, 1'b1);
            setp(1, AB'($urandom_range(0, 15) << 3), 1'b0, 8'h00, 64'h0, 1'b1);
            @(negedge clk);
            chk("t4_alt", 64'(o_req_ready), (i % 2 == 1) ? 64'h2 : 64'h1);
            g0 += int'(o_req_ready[0]);
            g1 += int'(o_req_ready[1]);
            step();
        end
        i_req_valid = 2'b00;
        chk("t4_cnt0", 64'(g0), 64'd5);
        chk("t4_cnt1", 64'(g1), 64'd5);
`ifdef SRAM_ARBITER2_STAT_EN
        @(negedge clk);
        chk("stat_grant0", 64'(o_stat_grant[0]), 64'd5);
        chk("stat_grant1", 64'(o_stat_grant[1]), 64'd5);
        chk("stat_conflict_ge9", 64'(o_stat_conflict >= 32'd9), 64'h1);
`endif

        // reset during beat 2 of a port 0 burst
        step();
        i_req_valid = 2'b01;
        setp(0, AB'(17'h10), 1'b0, 8'h00, 64'h0, 1'b0);
        @(negedge clk);
        chk("t5_beat1", 64'(o_req_ready), 64'h1);
        step();
        nrst = 1'b0;
        i_req_valid = 2'b11;
        setp(0, AB'(17'h18), 1'b0, 8'h00, 64'h0, 1'b0);
        setp(1, AB'(17'h20), 1'b0, 8'h00, 64'h0, 1'b1);
        @(negedge clk);
        chk("t5_in_reset", 64'(o_req_ready), 64'h0);
        step();
        nrst = 1'b1;
        i_req_valid = 2'b10;
        @(negedge clk);
        chk("t5_p1_grant", 64'(o_req_ready), 64'h2);
        chk("t5_resp", 64'(o_resp_valid), 64'h0);

        // randomized traffic, occasional reset, model checks every cycle
        for (int c = 0; c < 3000; c++) begin
            step();
            nrst = ($urandom_range(0, 199) != 0);
            for (int p = 0; p < 2; p++) begin
                i_req_valid[p] = ($urandom_range(0, 9) < 7);
                setp(p, AB'($urandom_range(0, 15) << 3), 1'($urandom_range(0, 1)),
                     8'($urandom), {$urandom, $urandom}, $urandom_range(0, 2) != 0);
            end
        end
        step();
        nrst = 1'b1;
        i_req_valid = 2'b00;
        step();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
